// File: rtl/multi_track_loader_pkg.sv
// multi_track_loader_pkg: engine states, sizes and the drive arbiter helper.
// MULTI_TRACK_LOADER_WRITEBACK_EN builds dirty-track writeback.
package multi_track_loader_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD_SETUP, RD} state_t;
  localparam int SECTOR_BYTES = 512;
  localparam int TSEC_W = 4;
`ifdef MULTI_TRACK_LOADER_WRITEBACK_EN
  localparam bit WRITEBACK = 1'b1;
`else
  localparam bit WRITEBACK = 1'b0;
`endif
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/multi_track_loader_chan.sv
// multi_track_loader_chan: per-drive mount, dirty, valid and loaded-track state.
// Dirty tracking is only kept with MULTI_TRACK_LOADER_WRITEBACK_EN.
module multi_track_loader_chan
  import multi_track_loader_pkg::*;
#(
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               mount,
  input  logic               present,
  input  logic               write_disk,
  input  logic               clr_dirty,
  input  logic               load,
  input  logic               done,
  input  logic [TRACK_W-1:0] track,
  output logic [TRACK_W-1:0] cur_track,
  output logic               needs_service,
  output logic               wb_req,
  output logic               ready
);
  logic mounted, dirty, valid, stale;
  assign needs_service = mounted && (!valid || track != cur_track);
  assign ready = mounted && !needs_service;
  assign wb_req = valid && dirty;
  // stale marks a remount that arrived mid-transfer, so the finished load is not trusted
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      mounted <= 1'b0;
      dirty <= 1'b0;
      valid <= 1'b0;
      stale <= 1'b0;
      cur_track <= '0;
    end else if (mount) begin
      mounted <= present;
      dirty <= 1'b0;
      valid <= 1'b0;
      stale <= 1'b1;
    end else begin
      if (load) begin
        cur_track <= track;
        valid <= 1'b0;
        stale <= 1'b0;
      end
      if (done) valid <= !stale;
      if (clr_dirty) dirty <= 1'b0;
      if (WRITEBACK && write_disk && mounted) dirty <= 1'b1;
    end
endmodule

// File: rtl/multi_track_loader.sv
// multi_track_loader: one SD block engine serialising track loads for all floppy drives.
// Dirty-track writeback before reload is built with MULTI_TRACK_LOADER_WRITEBACK_EN.
module multi_track_loader
  import multi_track_loader_pkg::*;
#(
  parameter int NUM_DRIVES = 2,
  parameter int SECTORS_PER_TRACK = 13,
  parameter int TRACK_W = 6,
  parameter int LBA_W = 32
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [NUM_DRIVES*TRACK_W-1:0] track,
  input  logic [NUM_DRIVES-1:0]         img_mounted,
  input  logic [63:0]                   img_size,
  input  logic [NUM_DRIVES-1:0]         fd_write_disk,
  output logic [NUM_DRIVES*LBA_W-1:0]   sd_lba,
  output logic [NUM_DRIVES-1:0]         sd_rd,
  output logic [NUM_DRIVES-1:0]         sd_wr,
  input  logic [NUM_DRIVES-1:0]         sd_ack,
  output logic [TSEC_W-1:0]             track_sec,
  output logic [1:0]                    sel,
  output logic                          cpu_wait,
  output logic [NUM_DRIVES-1:0]         drive_ready
);
  state_t state, state_n;
  logic [NUM_DRIVES-1:0] need, wb;
  logic [LBA_W-1:0] lba_r [NUM_DRIVES];
  logic [TRACK_W-1:0] cur [NUM_DRIVES];
  logic [3:0] need4, wb4, ack4;
  logic [1:0] pick;
  logic rd_q, wr_q, ack_q, ack_qq, go, go_wr, xfer, rise, fall, last, done;

  function automatic logic [LBA_W-1:0] lba_of(input logic [TRACK_W-1:0] t);
    return LBA_W'(t) * LBA_W'(SECTORS_PER_TRACK);
  endfunction

  assign need4 = 4'(need);
  assign wb4 = 4'(wb);
  assign ack4 = 4'(sd_ack);
  assign pick = lowest_set(need4);
  assign go = state == IDLE && |need;
  assign go_wr = wb4[pick];
  assign xfer = state == WR || state == RD;
  assign rise = ack_q && !ack_qq;
  assign fall = !ack_q && ack_qq;
  assign last = track_sec == TSEC_W'(SECTORS_PER_TRACK - 1);
  assign done = state == RD && fall && last;
  assign sd_rd = NUM_DRIVES'(rd_q) << sel;
  assign sd_wr = WRITEBACK ? NUM_DRIVES'(wr_q) << sel : '0;

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_ch
    multi_track_loader_chan #(.TRACK_W(TRACK_W)) u_chan (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .mount        (img_mounted[i]),
      .present      (|img_size),
      .write_disk   (fd_write_disk[i]),
      .clr_dirty    (go && go_wr && pick == 2'(i)),
      .load         (state == RD_SETUP && sel == 2'(i)),
      .done         (done && sel == 2'(i)),
      .track        (track[i*TRACK_W +: TRACK_W]),
      .cur_track    (cur[i]),
      .needs_service(need[i]),
      .wb_req       (wb[i]),
      .ready        (drive_ready[i])
    );
    assign sd_lba[i*LBA_W +: LBA_W] = lba_r[i];
  end

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !go ? IDLE : go_wr ? WR : RD_SETUP;
      WR:       state_n = fall && last ? RD_SETUP : WR;
      RD_SETUP: state_n = RD;
      RD:       state_n = done ? IDLE : RD;
      default:  state_n = IDLE;
    endcase
  end

  // the request drops on the last sector's ack rise; the phase ends on its fall
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      sel <= '0;
      cpu_wait <= 1'b0;
      track_sec <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ack_q <= 1'b0;
      ack_qq <= 1'b0;
      for (int i = 0; i < NUM_DRIVES; i++) lba_r[i] <= '0;
    end else begin
      ack_q <= ack4[sel];
      ack_qq <= ack_q;
      if (go) begin
        sel <= pick;
        cpu_wait <= 1'b1;
        track_sec <= '0;
        wr_q <= go_wr;
      end
      if (state == RD_SETUP) begin
        track_sec <= '0;
        rd_q <= 1'b1;
      end
      if (xfer && rise && last) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
      if (xfer && fall) track_sec <= last ? '0 : track_sec + 1'b1;
      if (done) cpu_wait <= 1'b0;
      for (int i = 0; i < NUM_DRIVES; i++)
        if (go && go_wr && pick == 2'(i)) lba_r[i] <= lba_of(cur[i]);
        else if (state == RD_SETUP && sel == 2'(i)) lba_r[i] <= lba_of(track[i*TRACK_W +: TRACK_W]);
        else if (xfer && rise && !last && sel == 2'(i)) lba_r[i] <= lba_r[i] + 1'b1;
    end
endmodule

// File: tb/tb_multi_track_loader.sv
// tb_multi_track_loader: directed table of track changes plus hand-written arbitration, unmount and reset sequences.
module tb_multi_track_loader;
  localparam int ND = 2, TW = 6, LW = 32, SPT = 13;
`ifdef MULTI_TRACK_LOADER_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [ND*TW-1:0] track = '0;
  logic [ND-1:0] img_mounted = '0, fd_write_disk = '0, sd_ack = '0;
  logic [63:0] img_size = 64'd143360;
  logic [ND*LW-1:0] sd_lba;
  logic [ND-1:0] sd_rd, sd_wr, drive_ready;
  logic [3:0] track_sec;
  logic [1:0] sel;
  logic cpu_wait;
  int checks = 0, errors = 0, low_cnt = 0;

  typedef struct {
    int drv;
    int trk;
    bit mount;
    bit wdirty;
    int wr_lba;
    int rd_lba;
  } vec_t;
  vec_t vt [6];

  multi_track_loader dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .fd_write_disk(fd_write_disk),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .track_sec    (track_sec),
    .sel          (sel),
    .cpu_wait     (cpu_wait),
    .drive_ready  (drive_ready)
  );

  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) if (!cpu_wait) low_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // HPS side: acknowledge n sectors of a request on channel ch, checking lba and sector index
  task automatic serve(input int ch, input bit wr, input int base, input int n);
    for (int s = 0; s < n; s++) begin
      int k;
      k = 0;
      while (!(wr ? sd_wr[ch] : sd_rd[ch]) && k < 100) begin
        @(negedge clk_sys);
        k++;
      end
      chk("req_seen", k < 100, 1);
      if (k >= 100) return;
      chk("lba", sd_lba[ch*LW +: LW], base + s);
      chk("track_sec", track_sec, s);
      chk("cpu_wait_busy", cpu_wait, 1);
      chk("sel", sel, ch);
      chk("other_chan_req", (sd_rd | sd_wr) & ~(ND'(1) << ch), 0);
      chk("opposite_req", wr ? sd_rd : sd_wr, 0);
      sd_ack[ch] = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("req_after_rise", wr ? sd_wr[ch] : sd_rd[ch], s != SPT - 1);
      if (s != SPT - 1) chk("lba_inc", sd_lba[ch*LW +: LW], base + s + 1);
      sd_ack[ch] = 1'b0;
      repeat (3) @(negedge clk_sys);
    end
  endtask

  task automatic settle(input int drv);
    repeat (3) @(negedge clk_sys);
    chk("drive_ready", drive_ready[drv], 1);
    chk("cpu_wait_done", cpu_wait, 0);
  endtask

  initial begin
    int l0, bad;
    vt[0] = '{0, 3, 1'b0, 1'b1, 0, 39};
    vt[1] = '{0, 5, 1'b0, 1'b0, 0, 65};
    vt[2] = '{0, 63, 1'b0, 1'b1, 65, 819};
    vt[3] = '{1, 10, 1'b1, 1'b0, 0, 130};
    vt[4] = '{1, 1, 1'b0, 1'b1, 130, 13};
    vt[5] = '{0, 2, 1'b1, 1'b0, 0, 26};

    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_drive_ready", drive_ready, 0);
    chk("rst_sel", sel, 0);
    chk("rst_track_sec", track_sec, 0);

    // first mount: cpu_wait one cycle after the need is seen, sd_rd one cycle later
    img_mounted[0] = 1'b1;
    @(negedge clk_sys);
    img_mounted = '0;
    chk("wait_t0", cpu_wait, 0);
    @(negedge clk_sys);
    chk("wait_t1", cpu_wait, 1);
    chk("rd_t1", sd_rd, 0);
    @(negedge clk_sys);
    chk("rd_t2", sd_rd, 1);
    chk("lba_t2", sd_lba[LW-1:0], 0);
    serve(0, 0, 0, SPT);
    settle(0);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].wdirty) begin
        fd_write_disk[vt[i].drv] = 1'b1;
        @(negedge clk_sys);
        fd_write_disk = '0;
      end
      track[vt[i].drv*TW +: TW] = TW'(vt[i].trk);
      if (vt[i].mount) img_mounted[vt[i].drv] = 1'b1;
      @(negedge clk_sys);
      img_mounted = '0;
      l0 = low_cnt;
      if (vt[i].wdirty && WB) begin
        serve(vt[i].drv, 1, vt[i].wr_lba, SPT);
        chk("wait_held_wr_rd", low_cnt - l0, 0);
      end
      serve(vt[i].drv, 0, vt[i].rd_lba, SPT);
      settle(vt[i].drv);
    end

    // simultaneous mounts: drive 0 wins, drive 1 waits its turn
    track = {TW'(7), TW'(4)};
    img_mounted = 2'b11;
    @(negedge clk_sys);
    img_mounted = '0;
    serve(0, 0, 52, SPT);
    serve(1, 0, 91, SPT);
    settle(1);
    chk("both_ready", drive_ready, 2'b11);

    // empty image unmounts: a track change raises no request
    img_size = '0;
    img_mounted[0] = 1'b1;
    @(negedge clk_sys);
    img_mounted = '0;
    track[TW-1:0] = TW'(9);
    bad = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (|sd_rd || |sd_wr || cpu_wait) bad++;
    end
    chk("no_req_unmounted", bad, 0);
    chk("unmounted_not_ready", drive_ready[0], 0);

    // reset during sector 5 of a read
    img_size = 64'd143360;
    track[TW-1:0] = TW'(6);
    img_mounted[0] = 1'b1;
    @(negedge clk_sys);
    img_mounted = '0;
    serve(0, 0, 78, 5);
    bad = 0;
    while (!sd_rd[0] && bad < 100) begin
      @(negedge clk_sys);
      bad++;
    end
    chk("sector5_lba", sd_lba[LW-1:0], 83);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_mid_sd_rd", sd_rd, 0);
    chk("rst_mid_cpu_wait", cpu_wait, 0);
    chk("rst_mid_ready", drive_ready, 0);
    reset = 1'b0;
    track[TW-1:0] = TW'(8);
    bad = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (|sd_rd || |sd_wr || cpu_wait) bad++;
    end
    chk("no_req_after_reset", bad, 0);
    img_mounted[0] = 1'b1;
    @(negedge clk_sys);
    img_mounted = '0;
    serve(0, 0, 104, SPT);
    settle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_track_loader.md
# multi_track_loader

Shared track-transfer engine for up to NUM_DRIVES floppy drives: one SD block interface, per-drive request/ack lines, and dirty-track writeback before the next track is loaded. Sits in the emu top between the apple2_top floppy ports and the HPS sd_* channels. One instance replaces a separate loader per drive and serialises all drive traffic. The CPU is held for the whole transfer, from the first sector to the last.

## Interface
Parameters:
- NUM_DRIVES, 2, number of drive channels (1..4)
- SECTORS_PER_TRACK, 13, 512-byte SD sectors per track
- TRACK_W, 6, track number width
- LBA_W, 32, LBA width per channel

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- track  in  NUM_DRIVES*TRACK_W  requested track per drive; drive n uses bits [n*TRACK_W +: TRACK_W]
- img_mounted  in  NUM_DRIVES  mount strobe per drive
- img_size  in  64  size of the image being mounted; nonzero means present
- fd_write_disk  in  NUM_DRIVES  per-drive strobe: emulator wrote the track buffer
- sd_lba  out  NUM_DRIVES*LBA_W  LBA per drive channel
- sd_rd  out  NUM_DRIVES  read request per channel
- sd_wr  out  NUM_DRIVES  write request per channel
- sd_ack  in  NUM_DRIVES  ack per channel from the HPS
- track_sec  out  4  sector index within the track; forms buffer address {track_sec, sd_buff_addr}
- sel  out  2  drive currently being serviced
- cpu_wait  out  1  stall the CPU while a transfer is in progress
- drive_ready  out  NUM_DRIVES  drive is mounted and its current track is loaded

## Operation
- Per-drive state: mounted, dirty, cur_track, valid.
- Mount strobe on drive n:
  - If img_size != 0: mounted=1, valid=0, dirty=0. Pending edits are discarded.
  - Otherwise mounted=0.
- fd_write_disk[n] sets dirty[n]. It is ignored while mounted[n]=0.
- A drive needs service when mounted && (!valid || track != cur_track).
- The engine has these states:
  - IDLE: pick the lowest-index drive needing service. Latch it into sel and assert cpu_wait. If it is valid and dirty, clear dirty and go to WR. Otherwise go to RD_SETUP.
  - WR: lba = SECTORS_PER_TRACK*cur_track, track_sec=0, sd_wr[sel]=1.
  - WR and RD both use the same per-sector handshake:
    - On sd_ack rising edge: if track_sec==SECTORS_PER_TRACK-1, drop the request; otherwise lba+1.
    - On sd_ack falling edge: track_sec+1.
    - After the falling edge of the last sector, WR goes to RD_SETUP and RD goes to IDLE.
  - RD_SETUP: cur_track = track (sampled here), track_sec=0, lba = SECTORS_PER_TRACK*track, sd_rd[sel]=1, go to RD.
  - RD completion: valid=1, cpu_wait=0, go to IDLE.
- If track changes during RD, the drive is re-serviced from IDLE once RD completes.
- Arithmetic: lba = SECTORS_PER_TRACK*track, zero-extended to LBA_W. track_sec wraps never occur because the last sector ends the phase.
- Only the channel in sel ever drives sd_rd or sd_wr. sd_lba of other channels holds its last value.
- A mount strobe on sel during WR/RD:
  - The current transfer completes.
  - The drive is then treated as freshly mounted, with valid=0.
- Unmounted drives are never serviced.

## Timing
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, track_sec=0, sel=0, cpu_wait=0, drive_ready=0, all mounted/dirty/valid=0, state IDLE.
- Edge detection uses a registered copy of sd_ack[sel]; edges act one cycle after the input edge.
- Read-only service:
  - Need detected in IDLE at cycle t: cpu_wait=1 and state RD_SETUP at t+1.
  - sd_rd and sd_lba become valid at t+2.
- Dirty service: sd_wr and sd_lba are valid at t+1.
- sd_lba is stable while a request is high and changes only on a registered ack rise.
- cpu_wait:
  - Goes high at t+1.
  - Falls one cycle after the registered last-sector ack fall.
  - Stays high continuously across WR->RD.
- Reset mid-transfer drops all requests immediately. All mounts are forgotten; a new mount strobe is required.

## Configuration
- Macro: MULTI_TRACK_LOADER_WRITEBACK_EN.
- Defined: dirty tracking and the WR state are built.
- Undefined:
  - sd_wr is tied to 0 and fd_write_disk is ignored.
  - IDLE always goes to RD_SETUP.
  - Edits are lost on track change.

## Structure
- Package multi_track_loader_pkg holds:
  - the state enum (IDLE, WR, RD_SETUP, RD)
  - SECTOR_BYTES=512
  - the track_sec width constant
  - a function computing the lowest-index set bit for drive selection
- Sub-module multi_track_loader_chan, one per drive: mounted, dirty, valid and cur_track registers, plus the needs_service output.
- The engine FSM and arbiter stay in the top module.

## Test plan
- Mount drive 0 with img_size=143360, track=0, ack every 4 cycles:
  - sd_rd[0] is requested with lba 0..12.
  - cpu_wait stays high for all 13 sectors, then drive_ready[0]=1.
- Drive 0 loaded, pulse fd_write_disk[0], set track=3:
  - WR phase with lba 0..12.
  - Then RD with lba 39..51.
  - cpu_wait never drops between the phases.
- Without MULTI_TRACK_LOADER_WRITEBACK_EN, same stimulus: no sd_wr pulse, only RD of lba 39..51.
- Drives 0 and 1 mounted in the same cycle:
  - Drive 0 is serviced first (sel=0), then drive 1 (sel=1).
  - sd_rd[1] stays low until drive 0 finishes.
- Mount with img_size=0, then change track: no request and drive_ready=0.
- Assert reset during sector 5 of RD:
  - Next cycle, sd_rd=0, cpu_wait=0 and drive_ready=0.
  - No request follows until a new mount strobe.
